// File: rtl/exec_mem_responder_if.sv
// Exec-unit memory port bundle: read/write requests and read response.
// master = execution unit side, slave = memory responder side.
interface exec_mem_responder_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
);
    logic                  exec_wr_req;
    logic [ADDR_WIDTH-1:0] exec_wr_addr;
    logic [DATA_WIDTH-1:0] exec_wr_data;
    logic                  exec_rd_req;
    logic [ADDR_WIDTH-1:0] exec_rd_addr;
    logic [DATA_WIDTH-1:0] exec_rd_data;
    logic                  exec_rd_valid;

    modport master (
        output exec_wr_req, exec_wr_addr, exec_wr_data,
        output exec_rd_req, exec_rd_addr,
        input  exec_rd_data, exec_rd_valid
    );

    modport slave (
        input  exec_wr_req, exec_wr_addr, exec_wr_data,
        input  exec_rd_req, exec_rd_addr,
        output exec_rd_data, exec_rd_valid
    );
endinterface

// File: rtl/exec_mem_responder.sv
// Memory-side responder for the exec unit port: fixed-latency reads,
// single-cycle writes, side-band preload, saturating request counters.
// Ports: clk, reset (sync, active-high); bus (exec_mem_responder_if.slave);
//   load_en/load_addr/load_data preload; addr_err pulse on out-of-range;
//   rd_count/wr_count accepted requests; par_inject/rd_parity_err parity.
// Optional build macro EXEC_MEM_PARITY_EN adds a stored even-parity bit.
module exec_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int MEM_DEPTH  = 4096,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    exec_mem_responder_if.slave   bus,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  addr_err,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
    input  logic                  par_inject,
    output logic                  rd_parity_err
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("RD_LATENCY must be 1..4");
    end

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic             rd_ok;
    logic             wr_ok;
    logic             ld_ok;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] ld_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic             rd_perr;

    // Full-width compare: addresses never wrap modulo the depth.
    assign rd_ok  = {1'b0, bus.exec_rd_addr} < DEPTH;
    assign wr_ok  = {1'b0, bus.exec_wr_addr} < DEPTH;
    assign ld_ok  = {1'b0, load_addr} < DEPTH;
    assign rd_idx = bus.exec_rd_addr[IDX_W-1:0];
    assign wr_idx = bus.exec_wr_addr[IDX_W-1:0];
    assign ld_idx = load_addr[IDX_W-1:0];
    assign rd_word = rd_ok ? mem[rd_idx] : '0;

    // Array is never reset. The exec write is issued after the preload,
    // so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (load_en && ld_ok)
            mem[ld_idx] <= load_data;
        if (!reset && bus.exec_wr_req && wr_ok)
            mem[wr_idx] <= bus.exec_wr_data;
    end

`ifdef EXEC_MEM_PARITY_EN
    logic par_mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (load_en && ld_ok)
            par_mem[ld_idx] <= ^load_data;
        if (!reset && bus.exec_wr_req && wr_ok)
            par_mem[wr_idx] <= (^bus.exec_wr_data) ^ par_inject;
    end

    assign rd_perr = rd_ok && (par_mem[rd_idx] != (^mem[rd_idx]));
`else
    logic unused_par_inject;
    assign unused_par_inject = par_inject;
    assign rd_perr = 1'b0;
`endif

    // Each stage only takes new data behind a valid word, so the last
    // stage holds the previous response between reads.
    logic                  pipe_v [RD_LATENCY];
    logic                  pipe_p [RD_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_d [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_p[i] <= 1'b0;
                pipe_d[i] <= '0;
            end
            addr_err <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            pipe_v[0] <= bus.exec_rd_req;
            pipe_p[0] <= bus.exec_rd_req && rd_perr;
            if (bus.exec_rd_req)
                pipe_d[0] <= rd_word;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_p[i] <= pipe_p[i-1];
                if (pipe_v[i-1])
                    pipe_d[i] <= pipe_d[i-1];
            end
            addr_err <= (bus.exec_rd_req && !rd_ok) ||
                        (bus.exec_wr_req && !wr_ok);
            if (bus.exec_rd_req && rd_count != 16'hFFFF)
                rd_count <= rd_count + 16'd1;
            if (bus.exec_wr_req && wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;
        end
    end

    assign bus.exec_rd_valid = pipe_v[RD_LATENCY-1];
    assign bus.exec_rd_data  = pipe_d[RD_LATENCY-1];
    assign rd_parity_err     = pipe_p[RD_LATENCY-1];

endmodule

// File: tb/tb_exec_mem_responder.sv
// Self-checking bench for exec_mem_responder (RD_LATENCY=3, MEM_DEPTH=1024):
// directed scenarios followed by random traffic against a queue-based model.
module tb_exec_mem_responder;

    localparam int LAT   = 3;
    localparam int DEPTH = 1024;
`ifdef EXEC_MEM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        bit          v;
        logic [11:0] d;
        bit          p;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [11:0] load_addr;
    logic [11:0] load_data;
    logic        addr_err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic        par_inject;
    logic        rd_parity_err;

    exec_mem_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(12)) bus ();

    exec_mem_responder #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(12),
        .MEM_DEPTH (DEPTH),
        .RD_LATENCY(LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .addr_err     (addr_err),
        .rd_count     (rd_count),
        .wr_count     (wr_count),
        .par_inject   (par_inject),
        .rd_parity_err(rd_parity_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [11:0] m   [DEPTH];
    bit          bad [DEPTH];
    resp_t       q [$];

    bit          exp_v;
    logic [11:0] exp_d;
    bit          exp_err;
    bit          exp_pe;
    int          exp_rc;
    int          exp_wc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        reset            = 1'b0;
        load_en          = 1'b0;
        load_addr        = '0;
        load_data        = '0;
        par_inject       = 1'b0;
        bus.exec_wr_req  = 1'b0;
        bus.exec_wr_addr = '0;
        bus.exec_wr_data = '0;
        bus.exec_rd_req  = 1'b0;
        bus.exec_rd_addr = '0;
    endtask

    // One clock: advance the model on the edge, then compare all outputs.
    task automatic tick();
        resp_t       e;
        int          ra;
        int          wa;
        int          la;
        logic [11:0] rv;
        @(posedge clk);
        ra = int'(bus.exec_rd_addr);
        wa = int'(bus.exec_wr_addr);
        la = int'(load_addr);
        if (reset) begin
            exp_v = 0; exp_d = '0; exp_err = 0; exp_pe = 0;
            exp_rc = 0; exp_wc = 0;
            q.delete();
            repeat (LAT - 1) q.push_back('{v: 1'b0, d: 12'd0, p: 1'b0});
        end else begin
            rv = (ra < DEPTH) ? m[ra] : 12'd0;
            q.push_back('{v: bus.exec_rd_req, d: rv,
                          p: bus.exec_rd_req && ra < DEPTH && bad[ra]});
            e = q.pop_front();
            exp_v = e.v;
            if (e.v) exp_d = e.d;
            exp_pe = PAR && e.p;
            exp_err = (bus.exec_rd_req && ra >= DEPTH) ||
                      (bus.exec_wr_req && wa >= DEPTH);
            if (bus.exec_rd_req && exp_rc < 65535) exp_rc++;
            if (bus.exec_wr_req && exp_wc < 65535) exp_wc++;
        end
        if (load_en && la < DEPTH) begin
            m[la] = load_data;
            bad[la] = 1'b0;
        end
        if (!reset && bus.exec_wr_req && wa < DEPTH) begin
            m[wa] = bus.exec_wr_data;
            bad[wa] = par_inject;
        end
        #1;
        chk("rd_valid", bus.exec_rd_valid, exp_v);
        chk("rd_data", bus.exec_rd_data, exp_d);
        chk("addr_err", addr_err, exp_err);
        chk("rd_count", rd_count, exp_rc);
        chk("wr_count", wr_count, exp_wc);
        chk("rd_parity_err", rd_parity_err, exp_pe);
        clear_inputs();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [11:0] pick();
        if ($urandom_range(0, 9) == 0)
            return 12'($urandom_range(DEPTH, 4095));
        if ($urandom_range(0, 1) == 0)
            return 12'($urandom_range(0, 15));
        return 12'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        clear_inputs();
        reset = 1'b1; tick();
        reset = 1'b1; tick();

        for (int i = 0; i < DEPTH; i++) begin
            load_en = 1; load_addr = 12'(i); load_data = 12'($urandom);
            tick();
        end
        reset = 1'b1; tick();

        // Preload then read back.
        load_en = 1; load_addr = 12'o100; load_data = 12'o1234; tick();
        bus.exec_rd_req = 1; bus.exec_rd_addr = 12'o100; tick();
        idle(LAT - 1);
        chk("t1_valid", bus.exec_rd_valid, 1);
        chk("t1_data", bus.exec_rd_data, 12'o1234);
        tick();
        chk("t1_pulse_end", bus.exec_rd_valid, 0);
        chk("t1_rd_count", rd_count, 1);

        // Write then read; same-cycle read-before-write.
        bus.exec_wr_req = 1; bus.exec_wr_addr = 12'o200;
        bus.exec_wr_data = 12'o7777; tick();
        bus.exec_rd_req = 1; bus.exec_rd_addr = 12'o200; tick();
        idle(LAT - 1);
        chk("t2_data", bus.exec_rd_data, 12'o7777);
        chk("t2_wr_count", wr_count, 1);
        load_en = 1; load_addr = 12'o200; load_data = 12'o0055; tick();
        bus.exec_wr_req = 1; bus.exec_wr_addr = 12'o200;
        bus.exec_wr_data = 12'o0011;
        bus.exec_rd_req = 1; bus.exec_rd_addr = 12'o200; tick();
        bus.exec_rd_req = 1; bus.exec_rd_addr = 12'o200; tick();
        idle(LAT - 2);
        chk("t2_rbw_old", bus.exec_rd_data, 12'o0055);
        tick();
        chk("t2_rbw_new", bus.exec_rd_data, 12'o0011);

        // Back-to-back reads return in order.
        for (int i = 0; i < 3; i++) begin
            load_en = 1; load_addr = 12'(i); load_data = 12'(5 + i); tick();
        end
        for (int i = 0; i < 3; i++) begin
            bus.exec_rd_req = 1; bus.exec_rd_addr = 12'(i); tick();
        end
        chk("t3_v0", bus.exec_rd_valid, 1);
        chk("t3_d0", bus.exec_rd_data, 5);
        tick();
        chk("t3_d1", bus.exec_rd_data, 6);
        tick();
        chk("t3_d2", bus.exec_rd_data, 7);
        tick();
        chk("t3_end", bus.exec_rd_valid, 0);

        // Reset flushes an in-flight read; array survives.
        load_en = 1; load_addr = 12'o300; load_data = 12'o4321; tick();
        bus.exec_rd_req = 1; bus.exec_rd_addr = 12'o300; tick();
        reset = 1; tick();
        for (int i = 0; i < LAT; i++) begin
            tick();
            chk("t4_flushed", bus.exec_rd_valid, 0);
        end
        chk("t4_rd_count", rd_count, 0);
        bus.exec_rd_req = 1; bus.exec_rd_addr = 12'o300; tick();
        idle(LAT - 1);
        chk("t4_survive", bus.exec_rd_data, 12'o4321);

        // Out-of-range read and write together.
        reset = 1; tick();
        bus.exec_wr_req = 1; bus.exec_wr_addr = 12'd1024;
        bus.exec_wr_data = 12'o1111;
        bus.exec_rd_req = 1; bus.exec_rd_addr = 12'd1024; tick();
        chk("t5_addr_err", addr_err, 1);
        tick();
        chk("t5_err_once", addr_err, 0);
        idle(LAT - 2);
        chk("t5_valid", bus.exec_rd_valid, 1);
        chk("t5_data", bus.exec_rd_data, 0);
        chk("t5_counts", {rd_count, wr_count}, {16'd1, 16'd1});
        bus.exec_rd_req = 1; bus.exec_rd_addr = 12'd0; tick();
        idle(LAT - 1);
        chk("t5_no_alias", bus.exec_rd_data, 5);

`ifdef EXEC_MEM_PARITY_EN
        bus.exec_wr_req = 1; bus.exec_wr_addr = 12'o10;
        bus.exec_wr_data = 12'o0001; par_inject = 1; tick();
        bus.exec_rd_req = 1; bus.exec_rd_addr = 12'o10; tick();
        idle(LAT - 1);
        chk("t6_data", bus.exec_rd_data, 12'o0001);
        chk("t6_perr", rd_parity_err, 1);
        bus.exec_wr_req = 1; bus.exec_wr_addr = 12'o10;
        bus.exec_wr_data = 12'o0001; tick();
        bus.exec_rd_req = 1; bus.exec_rd_addr = 12'o10; tick();
        idle(LAT - 1);
        chk("t6_perr_clr", rd_parity_err, 0);
`endif

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            bus.exec_rd_req  = $urandom_range(0, 1);
            bus.exec_rd_addr = pick();
            bus.exec_wr_req  = $urandom_range(0, 1);
            bus.exec_wr_addr = ($urandom_range(0, 3) == 0) ?
                               bus.exec_rd_addr : pick();
            bus.exec_wr_data = 12'($urandom);
            par_inject       = $urandom_range(0, 1);
            load_en          = ($urandom_range(0, 3) == 0);
            load_addr        = ($urandom_range(0, 1) == 0) ?
                               bus.exec_wr_addr : 12'($urandom_range(0, 15));
            if (int'(load_addr) >= DEPTH) load_addr = 12'd3;
            load_data        = 12'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_mem_responder.md
Name: exec_mem_responder

Overview:
- Active responder for the execution unit's memory port. It is the memory-side end of the exec_rd_req/exec_wr_req interface.
- Accepts single-cycle read and write requests from the execution unit and returns read data after a fixed, parameterised latency.
- Keeps a word array with a side-band preload port so benches can seed programs and operands.
- Counts transactions for scoreboard cross-checks; sits in place of memory_pdp in exec-unit-level benches.

Parameters:
- ADDR_WIDTH, 12, address width in bits.
- DATA_WIDTH, 12, word width in bits.
- MEM_DEPTH, 4096, number of words; addresses at or above MEM_DEPTH are out of range.
- RD_LATENCY, 1, cycles from read-request edge to data valid; legal values 1..4.

Ports:
- clk  in  1  free-running clock.
- reset  in  1  synchronous, active-high reset.
- exec_wr_req  in  1  write request, one cycle per write.
- exec_wr_addr  in  ADDR_WIDTH  write address.
- exec_wr_data  in  DATA_WIDTH  write data.
- exec_rd_req  in  1  read request, one cycle per read.
- exec_rd_addr  in  ADDR_WIDTH  read address.
- exec_rd_data  out  DATA_WIDTH  returned read data; holds its last value between reads.
- exec_rd_valid  out  1  one-cycle pulse, asserted with each returned word.
- load_en  in  1  preload write strobe (bench side).
- load_addr  in  ADDR_WIDTH  preload address.
- load_data  in  DATA_WIDTH  preload data.
- addr_err  out  1  one-cycle pulse on any out-of-range request.
- rd_count  out  16  accepted reads, saturating at 16'hFFFF.
- wr_count  out  16  accepted writes, saturating at 16'hFFFF.
- par_inject  in  1  parity corruption request; see Optional Feature.
- rd_parity_err  out  1  parity error pulse; see Optional Feature.

Behaviour:
- Reset, sampled at posedge clk:
  - exec_rd_data=0, exec_rd_valid=0, addr_err=0, rd_count=0, wr_count=0, rd_parity_err=0.
  - Read pipeline flushed; any read in flight is dropped and produces no valid pulse.
  - Memory array is NOT cleared; preloaded contents survive reset.
  - Requests presented during the reset cycle are ignored and not counted.
- Write:
  - exec_wr_req high at edge N commits mem[exec_wr_addr] at edge N.
  - wr_count increments at edge N.
- Read pipeline:
  - exec_rd_req high at edge N samples mem[exec_rd_addr] at edge N.
  - Data is driven on exec_rd_data with exec_rd_valid=1 in the cycle after edge N+RD_LATENCY-1. With RD_LATENCY=1, data is visible in the cycle directly after the request edge.
  - Implemented as a RD_LATENCY-deep shift register of {valid, data}. Back-to-back reads every cycle are supported; responses return in order.
  - rd_count increments at edge N.
- Simultaneous read and write, same cycle:
  - Different addresses: both are serviced.
  - Same address: read-before-write; the read returns the old word, and the write still commits.
  - A read in the cycle after a write returns the new word.
- Preload:
  - load_en commits mem[load_addr] at the edge and is not counted.
  - If exec_wr_req targets the same address in the same cycle, exec_wr_data wins.
  - load_en has no effect on the read pipeline.
- Out of range (address >= MEM_DEPTH):
  - Write is dropped.
  - Read returns 0 with a normal exec_rd_valid pulse.
  - addr_err pulses the cycle after the request edge.
  - The request is still counted.
  - If both read and write are out of range in one cycle, there is a single addr_err pulse.
- Counters: saturate and never wrap.
- Address arithmetic: none; addresses are used unmodified and do not wrap modulo MEM_DEPTH.
- No stall/backpressure: the responder is always ready, and every request is accepted in the cycle it is presented.

Optional Feature:
- Macro: EXEC_MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on exec write and on preload.
  - If par_inject is high during an exec write, the stored parity bit is inverted.
  - On read, parity is rechecked. On mismatch, rd_parity_err pulses together with exec_rd_valid; the data is returned unchanged.
  - Out-of-range reads never flag a parity error.
- Not defined:
  - No parity storage.
  - par_inject is ignored.
  - rd_parity_err is tied to 0.
  - Ports are present in both builds.

Test Plan:
- Preload mem[12'o100]=12'o1234, then read 12'o100 with RD_LATENCY=1 -> next cycle exec_rd_data=12'o1234, exec_rd_valid=1 for exactly one cycle; rd_count=1.
- Write 12'o7777 to 12'o200, then read 12'o200 the following cycle -> returns 12'o7777; wr_count=1. Read and write 12'o200 in the same cycle (mem holds 12'o0055, write 12'o0011) -> read returns 12'o0055, and a later read returns 12'o0011.
- RD_LATENCY=3: reads of 0, 1, 2 on three consecutive cycles (preloaded 5, 6, 7) -> valid pulses on three consecutive cycles, data 5, 6, 7 in order, the first appearing 3 cycles after its request edge.
- Issue a read to 12'o300 (RD_LATENCY=2), then assert reset one cycle later -> no exec_rd_valid pulse; counters=0; after reset a read of 12'o300 still returns the preloaded value.
- MEM_DEPTH=1024: read and write to address 1024 together -> exec_rd_data=0 with valid, a single addr_err pulse, memory unchanged, rd_count=1, wr_count=1.
- EXEC_MEM_PARITY_EN: write 12'o0001 to 12'o10 with par_inject=1, then read it -> exec_rd_data=12'o0001, rd_parity_err=1 with exec_rd_valid. Rewrite with par_inject=0 and read -> rd_parity_err=0.
